fetch_sequencer: RTL and testbench

- Owns the program counter (PC) and drives the word-indexed instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies pipeline control from later stages: stall (hazard unit), redirect (branch/jump resolution) and halt.
- Guards against fetches past the populated memory depth and counts issued fetches.

---
 rtl/fetch_sequencer_if.sv | 8 +
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction memory port between the fetch sequencer (master) and the instruction store (slave).
interface fetch_sequencer_if;
  logic [31:0] mem_address_o;
  logic [31:0] mem_instruction_i;

  modport master (output mem_address_o, input  mem_instruction_i);
  modport slave  (input  mem_address_o, output mem_instruction_i);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: owns the PC, fills the IF/ID register and applies halt/redirect/stall.
module fetch_sequencer #(
  parameter int unsigned MEM_DEPTH = 101,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_target_i,
  input  logic                      halt_i,
  fetch_sequencer_if.master         mem,
  output logic [31:0]               if_id_instr_o,
  output logic [31:0]               if_id_pc_o,
  output logic [31:0]               if_id_pc_plus1_o,
  output logic                      if_id_valid_o,
  output logic                      fault_o,
  output logic                      halted_o,
  output logic [31:0]               fetch_count_o
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FAULT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, pc_inc;
  logic [AW-1:0] instr_n, ifpc_n, ifpc1_n, count_n;
  logic          valid_n;

  assign mem.mem_address_o = pc;
  assign pc_inc            = pc + AW'(1);

  // State and pipeline registers; status flags are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_RUN;
      pc               <= RESET_PC;
      if_id_instr_o    <= '0;
      if_id_pc_o       <= '0;
      if_id_pc_plus1_o <= '0;
      if_id_valid_o    <= 1'b0;
      fetch_count_o    <= '0;
      fault_o          <= 1'b0;
      halted_o         <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      if_id_instr_o    <= instr_n;
      if_id_pc_o       <= ifpc_n;
      if_id_pc_plus1_o <= ifpc1_n;
      if_id_valid_o    <= valid_n;
      fetch_count_o    <= count_n;
      fault_o          <= (state_n == S_FAULT);
      halted_o         <= (state_n == S_HALT);
    end
  end

  // Next-state logic; priority halt > redirect > stall > normal fetch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = if_id_instr_o;
    ifpc_n  = if_id_pc_o;
    ifpc1_n = if_id_pc_plus1_o;
    valid_n = if_id_valid_o;
    count_n = fetch_count_o;

    unique case (state)
      S_RUN, S_FAULT: begin
        if (halt_i) begin
          state_n = S_HALT;
          valid_n = 1'b0;
        end else if (redirect_i) begin
          pc_n    = redirect_target_i;
          instr_n = '0;
          valid_n = 1'b0;
          state_n = (redirect_target_i >= DEPTH) ? S_FAULT : S_RUN;
        end else if (state == S_FAULT) begin
          valid_n = 1'b0;
        end else if (!stall_i) begin
          instr_n = mem.mem_instruction_i;
          ifpc_n  = pc;
          ifpc1_n = pc_inc;
          valid_n = 1'b1;
          count_n = fetch_count_o + AW'(1);
          pc_n    = pc_inc;
          if (pc_inc >= DEPTH) state_n = S_FAULT;
        end
      end
      S_HALT: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = S_HALT;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, halt_i;
  logic [31:0] redirect_target_i;
  logic [31:0] if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, fetch_count_o;
  logic        if_id_valid_o, fault_o, halted_o;

  int errors = 0;
  int checks = 0;

  fetch_sequencer_if mem_if ();

  fetch_sequencer #(.MEM_DEPTH(101), .RESET_PC(32'd0)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .halt_i            (halt_i),
    .mem               (mem_if.master),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_pc_plus1_o  (if_id_pc_plus1_o),
    .if_id_valid_o     (if_id_valid_o),
    .fault_o           (fault_o),
    .halted_o          (halted_o),
    .fetch_count_o     (fetch_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA5000000 ^ (a * 32'd7);
  endfunction

  assign mem_if.mem_instruction_i = word(mem_if.mem_address_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall_i = 0; redirect_i = 0; halt_i = 0; redirect_target_i = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, fetch_count_o, mem_if.mem_address_o} !== 160'd0) begin
      errors++;
      $display("FAIL reset_words: instr=%h pc=%h pc1=%h cnt=%h addr=%h want all 0",
               if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, fetch_count_o, mem_if.mem_address_o);
    end
    checks++;
    if ({if_id_valid_o, fault_o, halted_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: v/f/h=%b want 000", {if_id_valid_o, fault_o, halted_o});
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({if_id_pc_o, if_id_pc_plus1_o, if_id_instr_o, if_id_valid_o} !==
          {32'(i), 32'(i + 1), word(32'(i)), 1'b1}) begin
        errors++;
        $display("FAIL free_run[%0d]: pc=%0d pc1=%0d instr=%h v=%b want pc=%0d pc1=%0d instr=%h v=1",
                 i, if_id_pc_o, if_id_pc_plus1_o, if_id_instr_o, if_id_valid_o, i, i + 1, word(32'(i)));
      end
    end
    checks++;
    if ({fetch_count_o, mem_if.mem_address_o} !== {32'd5, 32'd5}) begin
      errors++;
      $display("FAIL free_run_count: cnt=%0d addr=%0d want 5/5", fetch_count_o, mem_if.mem_address_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_if.mem_address_o, if_id_pc_o, if_id_instr_o, fetch_count_o, if_id_valid_o} !==
          {32'd2, 32'd1, word(32'd1), 32'd2, 1'b1}) begin
        errors++;
        $display("FAIL stall[%0d]: addr=%0d pc=%0d instr=%h cnt=%0d v=%b want 2/1/%h/2/1",
                 i, mem_if.mem_address_o, if_id_pc_o, if_id_instr_o, fetch_count_o, if_id_valid_o, word(32'd1));
      end
    end
    stall_i = 0;
    tick();
    checks++;
    if ({if_id_pc_o, if_id_instr_o, fetch_count_o, if_id_valid_o} !== {32'd2, word(32'd2), 32'd3, 1'b1}) begin
      errors++;
      $display("FAIL stall_resume: pc=%0d instr=%h cnt=%0d v=%b want 2/%h/3/1",
               if_id_pc_o, if_id_instr_o, fetch_count_o, if_id_valid_o, word(32'd2));
    end
  endtask

  task automatic test_redirect_over_stall();
    tick();
    redirect_i = 1; redirect_target_i = 32'd5; stall_i = 1;
    tick();
    redirect_i = 0; stall_i = 0;
    checks++;
    if ({if_id_valid_o, mem_if.mem_address_o, if_id_instr_o, fetch_count_o} !== {1'b0, 32'd5, 32'd0, 32'd4}) begin
      errors++;
      $display("FAIL redirect_squash: v=%b addr=%0d instr=%h cnt=%0d want 0/5/0/4",
               if_id_valid_o, mem_if.mem_address_o, if_id_instr_o, fetch_count_o);
    end
    tick();
    checks++;
    if ({if_id_pc_o, if_id_valid_o, if_id_instr_o, fetch_count_o} !== {32'd5, 1'b1, word(32'd5), 32'd5}) begin
      errors++;
      $display("FAIL redirect_target: pc=%0d v=%b instr=%h cnt=%0d want 5/1/%h/5",
               if_id_pc_o, if_id_valid_o, if_id_instr_o, fetch_count_o, word(32'd5));
    end
  endtask

  task automatic test_fault();
    for (int k = 0; k < 95; k++) tick();
    checks++;
    if ({if_id_pc_o, if_id_instr_o, if_id_valid_o, fault_o, mem_if.mem_address_o, fetch_count_o} !==
        {32'd100, word(32'd100), 1'b1, 1'b1, 32'd101, 32'd100}) begin
      errors++;
      $display("FAIL last_word: pc=%0d instr=%h v=%b f=%b addr=%0d cnt=%0d want 100/%h/1/1/101/100",
               if_id_pc_o, if_id_instr_o, if_id_valid_o, fault_o, mem_if.mem_address_o, fetch_count_o, word(32'd100));
    end
    stall_i = 1;
    tick();
    tick();
    stall_i = 0;
    checks++;
    if ({if_id_valid_o, fault_o, mem_if.mem_address_o, fetch_count_o} !== {1'b0, 1'b1, 32'd101, 32'd100}) begin
      errors++;
      $display("FAIL fault_hold: v=%b f=%b addr=%0d cnt=%0d want 0/1/101/100",
               if_id_valid_o, fault_o, mem_if.mem_address_o, fetch_count_o);
    end
    redirect_i = 1; redirect_target_i = 32'd9;
    tick();
    redirect_i = 0;
    checks++;
    if ({fault_o, if_id_valid_o, mem_if.mem_address_o} !== {1'b0, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL fault_exit: f=%b v=%b addr=%0d want 0/0/9", fault_o, if_id_valid_o, mem_if.mem_address_o);
    end
    tick();
    checks++;
    if ({if_id_pc_o, if_id_valid_o, fetch_count_o} !== {32'd9, 1'b1, 32'd101}) begin
      errors++;
      $display("FAIL fault_resume: pc=%0d v=%b cnt=%0d want 9/1/101", if_id_pc_o, if_id_valid_o, fetch_count_o);
    end
    redirect_i = 1; redirect_target_i = 32'd200;
    tick();
    redirect_i = 0;
    checks++;
    if ({fault_o, if_id_valid_o, mem_if.mem_address_o} !== {1'b1, 1'b0, 32'd200}) begin
      errors++;
      $display("FAIL redirect_oob: f=%b v=%b addr=%0d want 1/0/200", fault_o, if_id_valid_o, mem_if.mem_address_o);
    end
    halt_i = 1;
    tick();
    halt_i = 0;
    checks++;
    if ({fault_o, halted_o, mem_if.mem_address_o} !== {1'b0, 1'b1, 32'd200}) begin
      errors++;
      $display("FAIL fault_halt: f=%b h=%b addr=%0d want 0/1/200", fault_o, halted_o, mem_if.mem_address_o);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick(); tick();
    halt_i = 1; redirect_i = 1; redirect_target_i = 32'd50;
    tick();
    halt_i = 0; redirect_i = 0;
    checks++;
    if ({halted_o, fault_o, if_id_valid_o, mem_if.mem_address_o, fetch_count_o} !== {1'b1, 1'b0, 1'b0, 32'd3, 32'd3}) begin
      errors++;
      $display("FAIL halt_entry: h=%b f=%b v=%b addr=%0d cnt=%0d want 1/0/0/3/3",
               halted_o, fault_o, if_id_valid_o, mem_if.mem_address_o, fetch_count_o);
    end
    stall_i = 1;
    tick();
    stall_i = 0; redirect_i = 1; redirect_target_i = 32'd60;
    tick();
    redirect_i = 0;
    tick();
    checks++;
    if ({halted_o, if_id_valid_o, mem_if.mem_address_o, fetch_count_o, if_id_pc_o} !==
        {1'b1, 1'b0, 32'd3, 32'd3, 32'd2}) begin
      errors++;
      $display("FAIL halt_sticky: h=%b v=%b addr=%0d cnt=%0d pc=%0d want 1/0/3/3/2",
               halted_o, if_id_valid_o, mem_if.mem_address_o, fetch_count_o, if_id_pc_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    stall_i = 1;
    tick();
    #2;
    rst = 1;
    #1;
    checks++;
    if ({if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, fetch_count_o, mem_if.mem_address_o,
         if_id_valid_o, fault_o, halted_o} !== 163'd0) begin
      errors++;
      $display("FAIL async_reset: instr=%h pc=%0d pc1=%0d cnt=%0d addr=%0d v/f/h=%b want all 0",
               if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, fetch_count_o, mem_if.mem_address_o,
               {if_id_valid_o, fault_o, halted_o});
    end
    tick();
    rst = 0; stall_i = 0;
    tick();
    checks++;
    if ({if_id_pc_o, if_id_valid_o, if_id_instr_o, fetch_count_o} !== {32'd0, 1'b1, word(32'd0), 32'd1}) begin
      errors++;
      $display("FAIL post_reset_fetch: pc=%0d v=%b instr=%h cnt=%0d want 0/1/%h/1",
               if_id_pc_o, if_id_valid_o, if_id_instr_o, fetch_count_o, word(32'd0));
    end
    tick();
    checks++;
    if ({if_id_pc_o, if_id_pc_plus1_o, mem_if.mem_address_o} !== {32'd1, 32'd2, 32'd2}) begin
      errors++;
      $display("FAIL post_reset_second: pc=%0d pc1=%0d addr=%0d want 1/2/2",
               if_id_pc_o, if_id_pc_plus1_o, mem_if.mem_address_o);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_fault();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
